// File: rtl/mult_share_arbiter.sv
// Shared array-multiplier arbiter for the matrix-inverse datapath.
// Grants one lockable owner at a time (round robin), muxes its operands onto
// the multiplier, and tracks issued ops through the fixed-latency pipeline
// so each result is strobed back to the requester that issued it.
//
// Handshake: req[i] is held high for a whole ownership session; gnt[i] is the
// registered grant. An op is accepted in any cycle where issue[i] and gnt[i]
// are both high (req[i] is not consulted). issue without gnt is dropped and
// raises the sticky err flag. result_valid[i] is a one-cycle strobe with no
// backpressure, aligned with array_mult_result for that op.
module mult_share_arbiter #(
  parameter int NREQ     = 3,
  parameter int LANES    = 15,
  parameter int W        = 36,
  parameter int MULT_LAT = 5
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req,
  input  logic [NREQ-1:0]                      issue,
  input  logic [NREQ-1:0][LANES-1:0][W-1:0]    dataa_in,
  input  logic [NREQ-1:0][LANES-1:0][W-1:0]    datab_in,
  output logic [NREQ-1:0]                      gnt,
  output logic [LANES-1:0][W-1:0]              array_mult_dataa,
  output logic [LANES-1:0][W-1:0]              array_mult_datab,
  input  logic [LANES-1:0][W-1:0]              array_mult_result,
  output logic [LANES-1:0][W-1:0]              result,
  output logic [NREQ-1:0]                      result_valid,
  output logic                                 busy,
  output logic                                 err,
  output logic [1:0]                           dbg_state_o
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWNED   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                        state_q;
  logic [NREQ-1:0]               gnt_q;
  logic [IDW-1:0]                ptr_q;
  logic [IDW-1:0]                owner_q;
  logic                          err_q, err_d;
  logic [MULT_LAT-1:0]           tag_vld_q, tag_vld_d;
  logic [MULT_LAT-1:0][IDW-1:0]  tag_id_q, tag_id_d;

  logic                          arb_found;
  logic [IDW-1:0]                arb_win;
  logic                          accept;
  logic                          viol;

  // Round-robin pick: first requester after the pointer; the loop runs
  // downward so the closest candidate is the last (winning) assignment.
  always_comb begin
    int idx;
    idx       = 0;
    arb_found = 1'b0;
    arb_win   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (req[idx[IDW-1:0]]) begin
        arb_found = 1'b1;
        arb_win   = idx[IDW-1:0];
      end
    end
  end

  // Ownership FSM; RELEASE is a single dead cycle that also arbitrates, so a
  // handover takes two cycles from req drop to new grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= IDW'(NREQ - 1);
      owner_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_RELEASE: begin
          if (arb_found) begin
            state_q <= S_OWNED;
            owner_q <= arb_win;
            ptr_q   <= arb_win;
            gnt_q   <= ONE << arb_win;
          end else begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
          end
        end
        S_OWNED: begin
          if (!req[owner_q]) begin
            state_q <= S_RELEASE;
            gnt_q   <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  // Accepted issue comes only from the granted owner; any other issue is a
  // protocol violation.
  always_comb begin
    accept = issue[owner_q] & gnt_q[owner_q];
    viol   = |(issue & ~gnt_q);
    err_d  = err_q | viol;
  end

  // Operand mux: zero unless the owner is issuing this cycle.
  always_comb begin
    array_mult_dataa = '0;
    array_mult_datab = '0;
    if (accept) begin
      array_mult_dataa = dataa_in[owner_q];
      array_mult_datab = datab_in[owner_q];
    end
  end

  // Tag shift register mirrors the multiplier pipeline; it drains
  // independently of who currently owns the multiplier.
  always_comb begin
    tag_vld_d[0] = accept;
    tag_id_d[0]  = owner_q;
    for (int s = 1; s < MULT_LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
  end

  // Tag pipeline and sticky error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      err_q     <= err_d;
    end
  end

  // Result strobe decode from the last tag stage.
  always_comb begin
    result_valid = '0;
    if (tag_vld_q[MULT_LAT-1]) begin
      result_valid[tag_id_q[MULT_LAT-1]] = 1'b1;
    end
  end

  assign gnt         = gnt_q;
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE) | (|tag_vld_q);
  assign result      = array_mult_result;
  assign dbg_state_o = state_q;

endmodule
